// File: rtl/stream_frame_monitor_if.sv
`default_nettype none
// ============================================================================
// stream_frame_monitor_if : AXI4-Stream pixel bus (valid/ready/data/last)
// Rev 1.0
// ============================================================================
interface stream_frame_monitor_if #(
    parameter int DATA_W = 24
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface
`default_nettype wire

// File: rtl/stream_frame_monitor.sv
`default_nettype none
// ============================================================================
// stream_frame_monitor : AXI4-Stream video sink with checksum and TLAST checks
// Rev 1.0
// ============================================================================
module stream_frame_monitor #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int CHANNELS     = 3,
    parameter int CHANNEL_BITS = 8,
    parameter int NUM_FRAMES   = 1,
    parameter int STALL_MODE   = 0,
    parameter int STALL_PERIOD = 4
) (
    input  wire logic              clock_i,
    input  wire logic              reset_ni,
    input  wire logic              enable_i,
    stream_frame_monitor_if.slave  slave,
    output logic                   frame_done_o,
    output logic [31:0]            checksum_o,
    output logic [15:0]            frame_count_o,
    output logic [15:0]            error_count_o,
    output logic                   error_last_o,
    output logic                   finished_o
);
    localparam int DATA_W = CHANNELS * CHANNEL_BITS;
    localparam int COL_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CYC_W  = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    if (DATA_W > 32) begin : g_width_check
        $error("stream_frame_monitor: CHANNELS*CHANNEL_BITS must not exceed 32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic               ready_reg;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [31:0]        sum;
    logic [CYC_W-1:0]   cyc;
    logic [15:0]        lfsr;

    logic               xfer;
    logic               frame_end;
    logic               hits_target;
    logic [31:0]        sum_next;
    logic [CYC_W-1:0]   cyc_next;
    logic [15:0]        lfsr_next;
    logic               stall_ok;

    assign slave.ready = ready_reg;

    // Stall sources only advance in RUN; ready is registered from their next-cycle value.
    always_comb begin
        xfer        = slave.valid & ready_reg;
        frame_end   = (row == ROW_W'(HEIGHT - 1)) && (col == COL_W'(WIDTH - 1));
        sum_next    = {sum[30:0], sum[31]} + 32'(slave.data);
        hits_target = (NUM_FRAMES != 0) && ((frame_count_o + 16'd1) == 16'(NUM_FRAMES));
        cyc_next    = cyc;
        lfsr_next   = lfsr;
        if (state == RUN) begin
            cyc_next  = (cyc == CYC_W'(STALL_PERIOD - 1)) ? '0 : cyc + CYC_W'(1);
            lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
        if (STALL_MODE == 1) begin
            stall_ok = (cyc_next != CYC_W'(STALL_PERIOD - 1));
        end else if (STALL_MODE == 2) begin
            stall_ok = lfsr_next[0];
        end else begin
            stall_ok = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state         <= IDLE;
            ready_reg     <= 1'b0;
            col           <= '0;
            row           <= '0;
            sum           <= '0;
            cyc           <= '0;
            lfsr          <= 16'hACE1;
            frame_done_o  <= 1'b0;
            checksum_o    <= '0;
            frame_count_o <= '0;
            error_count_o <= '0;
            error_last_o  <= 1'b0;
            finished_o    <= 1'b0;
        end else begin
            cyc          <= cyc_next;
            lfsr         <= lfsr_next;
            frame_done_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state     <= RUN;
                        ready_reg <= stall_ok;
                    end else begin
                        ready_reg <= 1'b0;
                    end
                end
                RUN: begin
                    if (xfer && frame_end && hits_target) begin
                        state      <= DONE;
                        ready_reg  <= 1'b0;
                        finished_o <= 1'b1;
                    end else if (!enable_i) begin
                        state     <= IDLE;
                        ready_reg <= 1'b0;
                    end else begin
                        ready_reg <= stall_ok;
                    end
                end
                DONE: begin
                    ready_reg <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    ready_reg <= 1'b0;
                end
            endcase

            // Framing comes from the counters alone, so a bad TLAST never shifts frame boundaries.
            if (xfer) begin
                if (frame_end) begin
                    checksum_o    <= sum_next;
                    sum           <= '0;
                    frame_count_o <= frame_count_o + 16'd1;
                    frame_done_o  <= 1'b1;
                    col           <= '0;
                    row           <= '0;
                end else begin
                    sum <= sum_next;
                    if (col == COL_W'(WIDTH - 1)) begin
                        col <= '0;
                        row <= row + ROW_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                if (slave.last != frame_end) begin
                    error_last_o <= 1'b1;
                    if (error_count_o != 16'hFFFF) begin
                        error_count_o <= error_count_o + 16'd1;
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_stream_frame_monitor.sv
`default_nettype none
// tb_stream_frame_monitor: five differently configured monitors, each compared every
// cycle against a beat-level model of the stream sink.
module tb_stream_frame_monitor;
    localparam int N = 5;

    function automatic int cfg_w(input int g);
        case (g) 0: return 2; 1: return 4; 2: return 4; 3: return 3; default: return 1; endcase
    endfunction
    function automatic int cfg_h(input int g);
        case (g) 0: return 1; 1: return 2; 2: return 2; 3: return 2; default: return 1; endcase
    endfunction
    function automatic int cfg_nf(input int g);
        case (g) 0: return 1; 3: return 3; default: return 0; endcase
    endfunction
    function automatic int cfg_mode(input int g);
        case (g) 2: return 1; 3: return 2; default: return 0; endcase
    endfunction
    function automatic int cfg_per(input int g);
        return (g >= 0) ? 4 : 4;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  [N];
    logic        enable [N];
    logic        valid  [N];
    logic [23:0] data   [N];
    logic        last   [N];
    logic        ready  [N];
    logic        done   [N];
    logic [31:0] csum   [N];
    logic [15:0] fcnt   [N];
    logic [15:0] ecnt   [N];
    logic        elast  [N];
    logic        fin    [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        stream_frame_monitor_if #(.DATA_W(24)) bus ();
        assign bus.valid = valid[g];
        assign bus.data  = data[g];
        assign bus.last  = last[g];
        assign ready[g]  = bus.ready;

        stream_frame_monitor #(
            .WIDTH       (cfg_w(g)),
            .HEIGHT      (cfg_h(g)),
            .CHANNELS    (3),
            .CHANNEL_BITS(8),
            .NUM_FRAMES  (cfg_nf(g)),
            .STALL_MODE  (cfg_mode(g)),
            .STALL_PERIOD(cfg_per(g))
        ) dut (
            .clock_i      (clk),
            .reset_ni     (rst_n[g]),
            .enable_i     (enable[g]),
            .slave        (bus.slave),
            .frame_done_o (done[g]),
            .checksum_o   (csum[g]),
            .frame_count_o(fcnt[g]),
            .error_count_o(ecnt[g]),
            .error_last_o (elast[g]),
            .finished_o   (fin[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;
    int pulses [N];

    task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, inst, $time, act, exp);
        end
    endtask

    // Model: pixel index within the frame, running checksum, and a count of RUN cycles.
    bit          m_run [N], m_fin [N], m_pulse [N], m_ready [N], m_errl [N];
    int          m_beat [N], m_frames [N], m_errs [N], m_runcyc [N];
    logic [31:0] m_sum [N], m_chk [N];
    logic [15:0] m_lfsr [N];

    task automatic model_step(input int i);
        bit fend;
        if (rst_n[i] !== 1'b1) begin
            m_run[i] = 0; m_fin[i] = 0; m_pulse[i] = 0; m_ready[i] = 0; m_errl[i] = 0;
            m_beat[i] = 0; m_frames[i] = 0; m_errs[i] = 0; m_runcyc[i] = 0;
            m_sum[i] = '0; m_chk[i] = '0; m_lfsr[i] = 16'hACE1;
        end else begin
            m_pulse[i] = 0;
            if (valid[i] === 1'b1 && m_ready[i]) begin
                fend = (m_beat[i] == cfg_w(i) * cfg_h(i) - 1);
                if (last[i] !== logic'(fend)) begin
                    m_errl[i] = 1;
                    if (m_errs[i] < 65535) m_errs[i]++;
                end
                m_sum[i] = {m_sum[i][30:0], m_sum[i][31]} + 32'(data[i]);
                if (fend) begin
                    m_chk[i] = m_sum[i];
                    m_sum[i] = '0;
                    m_frames[i]++;
                    m_pulse[i] = 1;
                    m_beat[i] = 0;
                    if (cfg_nf(i) != 0 && m_frames[i] == cfg_nf(i)) m_fin[i] = 1;
                end else begin
                    m_beat[i]++;
                end
            end
            if (m_run[i]) begin
                m_runcyc[i]++;
                m_lfsr[i] = {m_lfsr[i][14:0], m_lfsr[i][15] ^ m_lfsr[i][13] ^ m_lfsr[i][12] ^ m_lfsr[i][10]};
            end
            m_run[i] = (enable[i] === 1'b1) && !m_fin[i];
            if (!m_run[i])               m_ready[i] = 0;
            else if (cfg_mode(i) == 1)   m_ready[i] = (m_runcyc[i] % cfg_per(i)) != cfg_per(i) - 1;
            else if (cfg_mode(i) == 2)   m_ready[i] = m_lfsr[i][0];
            else                         m_ready[i] = 1;
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) model_step(i);
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < N; i++) begin
                check("ready",       i, 32'(ready[i]), 32'(m_ready[i]));
                check("frame_done",  i, 32'(done[i]),  32'(m_pulse[i]));
                check("checksum",    i, csum[i],       m_chk[i]);
                check("frame_count", i, 32'(fcnt[i]),  32'(m_frames[i] % 65536));
                check("error_count", i, 32'(ecnt[i]),  32'(m_errs[i]));
                check("error_last",  i, 32'(elast[i]), 32'(m_errl[i]));
                check("finished",    i, 32'(fin[i]),   32'(m_fin[i]));
                if (done[i] === 1'b1) pulses[i]++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called and returns at a negedge; holds the beat until a ready edge takes it.
    task automatic beat(input int i, input logic [23:0] d, input logic l);
        bit sent = 0;
        valid[i] = 1'b1; data[i] = d; last[i] = l;
        for (int k = 0; k < 100 && !sent; k++) begin
            sent = (ready[i] === 1'b1);
            @(negedge clk);
        end
        valid[i] = 1'b0; last[i] = 1'b0;
        if (!sent) begin
            n_cmp++; n_bad++;
            $display("FAIL beat_timeout[%0d]: ready stayed low for 100 cycles, required a transfer", i);
        end
    endtask

    task automatic ramp_frame(input int i, input int last_at, input int from, input int upto);
        for (int p = from; p <= upto; p++) beat(i, 24'(p), logic'(p == last_at));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            rst_n[i] = 0; enable[i] = 0; valid[i] = 0; data[i] = '0; last[i] = 0; pulses[i] = 0;
        end
        @(negedge clk);
        checking = 1'b1;
        check("rst_checksum", 1, csum[1], 32'h0);
        check("rst_ready",    1, 32'(ready[1]), 32'h0);
        check("rst_count",    1, 32'(fcnt[1]), 32'h0);
        @(negedge clk);
        for (int i = 0; i < N; i++) rst_n[i] = 1;

        // Two-pixel single frame, then finished
        enable[0] = 1;
        beat(0, 24'h000001, 1'b0);
        beat(0, 24'h000002, 1'b1);
        idle(2);
        check("t1_checksum", 0, csum[0], 32'h0000_0004);
        check("t1_finished", 0, 32'(fin[0]), 32'h1);
        check("t1_ready",    0, 32'(ready[0]), 32'h0);
        check("t1_pulses",   0, 32'(pulses[0]), 32'h1);

        // Ramp frames on 4x2: clean, clean, then bad TLAST twice
        enable[1] = 1;
        ramp_frame(1, 7, 0, 7);
        check("t2_checksum_f1", 1, csum[1], 32'h0000_00F7);
        ramp_frame(1, 7, 0, 7);
        check("t2_checksum_f2", 1, csum[1], 32'h0000_00F7);
        check("t2_count",       1, 32'(fcnt[1]), 32'h2);
        check("t2_errors",      1, 32'(ecnt[1]), 32'h0);
        ramp_frame(1, 3, 0, 7);
        check("t5_errors",     1, 32'(ecnt[1]), 32'h2);
        check("t5_error_last", 1, 32'(elast[1]), 32'h1);
        check("t5_count",      1, 32'(fcnt[1]), 32'h3);

        // Mid-frame reset, then a clean frame with a 10-cycle pause
        ramp_frame(1, 7, 0, 4);
        rst_n[1] = 0;
        @(negedge clk);
        check("t6_rst_count", 1, 32'(fcnt[1]), 32'h0);
        rst_n[1] = 1;
        ramp_frame(1, 7, 0, 3);
        enable[1] = 0;
        idle(10);
        check("t6_pause_ready", 1, 32'(ready[1]), 32'h0);
        enable[1] = 1;
        ramp_frame(1, 7, 4, 7);
        check("t6_checksum", 1, csum[1], 32'h0000_00F7);
        check("t6_count",    1, 32'(fcnt[1]), 32'h1);
        check("t6_errors",   1, 32'(ecnt[1]), 32'h0);

        // Random data, gaps, pauses and occasional TLAST faults
        for (int b = 0; b < 48; b++) begin
            if ($urandom_range(0, 7) == 0) begin
                enable[1] = 0;
                idle($urandom_range(1, 4));
                enable[1] = 1;
            end
            idle($urandom_range(0, 2));
            beat(1, 24'($urandom), logic'(((b % 8) == 7) ^ ($urandom_range(0, 9) == 0)));
        end

        // Periodic stall: ready low on every 4th RUN cycle
        enable[2] = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t3_stall_pattern", 2, 32'(ready[2]), (k % 4 == 3) ? 32'h0 : 32'h1);
        end
        ramp_frame(2, 7, 0, 7);
        ramp_frame(2, 7, 0, 7);
        check("t3_checksum", 2, csum[2], 32'h0000_00F7);
        check("t3_count",    2, 32'(fcnt[2]), 32'h2);

        // LFSR stall with random valid gaps, three frames then finished
        enable[3] = 1;
        @(negedge clk);
        check("t4_first_ready", 3, 32'(ready[3]), 32'h1);
        for (int b = 0; b < 18; b++) begin
            idle($urandom_range(0, 3));
            beat(3, 24'($urandom), logic'((b % 6) == 5));
        end
        idle(2);
        check("t4_finished", 3, 32'(fin[3]), 32'h1);
        check("t4_count",    3, 32'(fcnt[3]), 32'h3);
        check("t4_ready",    3, 32'(ready[3]), 32'h0);

        // 1x1 frames: every beat ends a frame
        enable[4] = 1;
        beat(4, 24'h5, 1'b1);
        beat(4, 24'h6, 1'b0);
        beat(4, 24'h7, 1'b1);
        beat(4, 24'h8, 1'b1);
        idle(2);
        check("w1_checksum", 4, csum[4], 32'h0000_0008);
        check("w1_count",    4, 32'(fcnt[4]), 32'h4);
        check("w1_errors",   4, 32'(ecnt[4]), 32'h1);

        for (int i = 0; i < N; i++) enable[i] = 0;
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
